// File: rtl/if_fetch_pkg.sv
// Shared CPU definitions for the instruction fetch stage: FSM encoding,
// the canonical NOP used for IF/ID bubbles, and the default reset vector.
package if_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    FULL  = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_fetch_adder.sv
// Plain 32-bit ripple-style adder used for the sequential PC increment.
module adder_32bits (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        ci,
  output logic [31:0] s,
  output logic        co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + {32'b0, ci};

endmodule

// File: rtl/if_fetch.sv
// Instruction fetch stage: single-outstanding imem request, one-entry hold
// buffer for load-use stalls, and redirect handling that never leaks stale words.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        IFWrite,
  input  logic        Branch,
  input  logic        Jump,
  input  logic [31:0] JumpAddr,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] Instruction_id,
  output logic [31:0] PC_id,
  output logic        valid_id
);

  fetch_state_t state, state_d;
  logic [31:0]  pc, pc_d;
  logic [31:0]  target, target_d;
  logic [31:0]  hold, hold_d;
  logic [31:0]  instr_d, pcid_d;
  logic         valid_d;
  logic [31:0]  pc_plus4;
  logic         pc_carry_unused;
  logic         redirect_take;
  logic [31:0]  jump_target;

  adder_32bits u_pc_inc (
    .a  (pc),
    .b  (32'd4),
    .ci (1'b0),
    .s  (pc_plus4),
    .co (pc_carry_unused)
  );

  // A redirect only counts for a real instruction that ID is allowed to advance.
  assign redirect_take = (Branch | Jump) & valid_id & IFWrite;
  assign jump_target   = JumpAddr & 32'hFFFF_FFFC;

  always_comb begin
    state_d   = state;
    pc_d      = pc;
    target_d  = target;
    hold_d    = hold;
    instr_d   = Instruction_id;
    pcid_d    = PC_id;
    valid_d   = valid_id;
    imem_req  = 1'b1;
    imem_addr = pc;

    case (state)
      FETCH: begin
        if (redirect_take) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          if (imem_ready) begin
            pc_d = jump_target;
          end else begin
            // Memory still owes us a word for the old pc; wait it out.
            target_d = jump_target;
            state_d  = DRAIN;
          end
        end else if (imem_ready) begin
          if (IFWrite) begin
            instr_d = imem_rdata;
            pcid_d  = pc;
            valid_d = 1'b1;
            pc_d    = pc_plus4;
          end else begin
            hold_d  = imem_rdata;
            state_d = FULL;
          end
        end else if (IFWrite) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end
      end

      FULL: begin
        imem_req = 1'b0;
        if (redirect_take) begin
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
          pc_d    = jump_target;
          state_d = FETCH;
        end else if (IFWrite) begin
          instr_d = hold;
          pcid_d  = pc;
          valid_d = 1'b1;
          pc_d    = pc_plus4;
          state_d = FETCH;
        end
      end

      DRAIN: begin
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
        if (imem_ready) begin
          pc_d    = target;
          state_d = FETCH;
        end
      end

      default: begin
        state_d = FETCH;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state          <= FETCH;
      pc             <= RESET_PC;
      target         <= 32'h0;
      hold           <= 32'h0;
      Instruction_id <= NOP_INSTR;
      PC_id          <= 32'h0;
      valid_id       <= 1'b0;
    end else begin
      state          <= state_d;
      pc             <= pc_d;
      target         <= target_d;
      hold           <= hold_d;
      Instruction_id <= instr_d;
      PC_id          <= pcid_d;
      valid_id       <= valid_d;
    end
  end

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 SHALL have port clk  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port IFWrite  input  1  ID stage may accept a new instruction (low = load-use stall).
REQ-005 SHALL have ports Branch, Jump  input  1 each  ID stage redirect requests for the instruction in PC_id.
REQ-006 SHALL have port JumpAddr  input  32  redirect target from ID.
REQ-007 SHALL have ports imem_req output 1 and imem_addr output 32, the instruction-memory request and address.
REQ-008 SHALL have ports imem_ready input 1 and imem_rdata input 32, meaning the response word is valid this cycle.
REQ-009 SHALL have ports Instruction_id output 32, PC_id output 32 and valid_id output 1, the registered IF/ID contents.

Function
REQ-010 SHALL define redirect_take = (Branch | Jump) & valid_id & IFWrite; Branch or Jump while stalled or while valid_id=0 is ignored.
REQ-011 SHALL implement states FETCH, FULL and DRAIN.
REQ-012 SHALL hold imem_req and imem_addr stable from assertion until the cycle imem_ready=1; the memory has one outstanding request at most.
REQ-013 SHALL, in FETCH: imem_req=1 and imem_addr=pc.
REQ-014 SHALL, in FETCH with imem_ready=1, IFWrite=1 and no redirect_take: load IF/ID with {imem_rdata, pc, 1}, set pc<=pc+4, and stay in FETCH (one instruction per cycle at zero-wait memory).
REQ-015 SHALL, in FETCH with imem_ready=1 and IFWrite=0: capture imem_rdata into the hold register, keep pc, hold IF/ID, and go to FULL.
REQ-016 SHALL, in FETCH with imem_ready=0 and IFWrite=1: load IF/ID with a bubble (32'h0000_0013, PC_id unchanged, valid_id=0).
REQ-017 SHALL, in FULL: imem_req=0; if IFWrite=1, load IF/ID from the hold register with pc and valid_id=1, set pc<=pc+4 and go to FETCH; if IFWrite=0, hold everything.
REQ-018 SHALL, on redirect_take: flush IF/ID to a bubble and apply pc <= {JumpAddr[31:2],2'b00}, as follows.
REQ-018a FETCH with imem_ready=1: discard the response, take the new pc at once, and stay in FETCH.
REQ-018b FETCH with imem_ready=0: latch the target, keep the old address, and go to DRAIN.
REQ-018c FULL: discard the hold register, take the new pc, and go to FETCH.
REQ-019 SHALL, in DRAIN: keep imem_req=1 and the old address; on imem_ready=1, discard the data, set pc<=target and go to FETCH; the IF/ID register keeps bubbles meanwhile, so no redirect can occur.
REQ-020 SHALL compute pc+4 modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
REQ-021 SHALL never present a word fetched before a redirect with valid_id=1 after that redirect.

Reset
REQ-022 SHALL, while reset=1 (asynchronous): set state=FETCH, pc=RESET_PC, Instruction_id=32'h0000_0013, PC_id=0, valid_id=0 and the hold register=0.
REQ-023 SHALL, when reset asserts mid-request, abandon that request; the memory side is reset on the same signal.
REQ-024 SHALL assert imem_req=1 with imem_addr=RESET_PC in the first cycle after reset deasserts.

Structure
REQ-025 SHALL place the state encoding, the NOP constant 32'h0000_0013 and the RESET_PC default in the shared CPU package.
REQ-026 SHALL compute pc+4 and keep the rest in one module, using a single instance of adder_32bits with ci=0 and b=4.

Verification
REQ-027 Zero-wait stream: imem_ready=1 always, IFWrite=1 -> PC_id = 0, 4, 8, 12 on consecutive cycles, valid_id=1 from cycle 2.
REQ-028 Stall: IFWrite=0 for 3 cycles while the word at 0x8 returns -> FULL is entered, imem_req=0, IF/ID holds PC_id=0x4, then PC_id=0x8 appears on the first IFWrite=1 cycle.
REQ-029 Redirect with ready: Jump=1, JumpAddr=0x100, imem_ready=1 -> next IF/ID is a bubble and the next imem_addr=0x100.
REQ-030 Redirect while waiting: Branch=1, JumpAddr=0x40, imem_ready=0 for 2 more cycles -> imem_addr stays at the old value, the response is discarded with valid_id=0, then imem_addr=0x40.
REQ-031 Wrap: RESET_PC=32'hFFFF_FFFC -> second fetch address is 0x0.
REQ-032 Reset pulse during DRAIN -> outputs return to the REQ-022 values immediately, and the first request after release is to RESET_PC.
